// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the register file and its scoreboard.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] regaddr_t;

  // Hard-wired zero register: reads 0, never written, never busy.
  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W     = $bits(word_t),
  parameter int ADDR_W     = $bits(regaddr_t),
  parameter int READ_PORTS = 2
);

  logic [READ_PORTS*ADDR_W-1:0] read_addr_i;
  logic [READ_PORTS*DATA_W-1:0] read_data_o;
  logic [READ_PORTS-1:0]        read_busy_o;
  logic                         reserve_valid_i;
  logic [ADDR_W-1:0]            reserve_addr_i;
  logic                         reserve_ready_o;
  logic                         write_enable_i;
  logic [ADDR_W-1:0]            write_addr_i;
  logic [DATA_W-1:0]            write_data_i;
  logic [ADDR_W:0]              busy_count_o;

  modport master (
    output read_addr_i, reserve_valid_i, reserve_addr_i,
           write_enable_i, write_addr_i, write_data_i,
    input  read_data_o, read_busy_o, reserve_ready_o, busy_count_o
  );

  modport slave (
    input  read_addr_i, reserve_valid_i, reserve_addr_i,
           write_enable_i, write_addr_i, write_data_i,
    output read_data_o, read_busy_o, reserve_ready_o, busy_count_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set by an accepted
// reserve and cleared by writeback, plus an incrementally kept busy count.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = $bits(regaddr_t)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reserve_valid_i,
  input  logic [ADDR_W-1:0]       reserve_addr_i,
  input  logic                    write_enable_i,
  input  logic [ADDR_W-1:0]       write_addr_i,
  output logic                    reserve_ready_o,
  output logic [ADDR_W:0]         busy_count_o,
  output logic [(2**ADDR_W)-1:0]  busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             res_nonzero;
  logic             wr_hit;
  logic             same_reg;
  logic             set_req;
  logic             inc;
  logic             dec;

  // Handshake, next busy vector and count delta; a same-register set wins over the clear.
  always_comb begin
    res_nonzero     = (reserve_addr_i != ADDR_W'(REG_ZERO));
    wr_hit          = write_enable_i && (write_addr_i != ADDR_W'(REG_ZERO));
    same_reg        = wr_hit && (write_addr_i == reserve_addr_i);
    // Only the reserve address feeds ready, never a read address.
    reserve_ready_o = reserve_valid_i &&
                      (!res_nonzero || !busy_q[reserve_addr_i] || same_reg);
    set_req         = reserve_ready_o && res_nonzero;
    inc             = set_req && !busy_q[reserve_addr_i];
    // A clear overridden by a same-register set does not lower the count.
    dec             = wr_hit && busy_q[write_addr_i] && !(set_req && same_reg);

    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[write_addr_i] = 1'b0;
    end
    if (set_req) begin
      busy_d[reserve_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;

    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (dec && !inc) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  // Busy bits and count share one edge; reset discards all pending state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with asynchronous reads, optional writeback
// forwarding, one write port and an integrated write-pending scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W     = $bits(word_t),
  parameter int ADDR_W     = $bits(regaddr_t),
  parameter int READ_PORTS = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_hit;

  // Next storage contents: writeback updates one register, r0 is never written.
  always_comb begin
    mem_d  = mem_q;
    wr_hit = bus.write_enable_i && (bus.write_addr_i != ADDR_W'(REG_ZERO));
    if (wr_hit) begin
      mem_d[bus.write_addr_i] = bus.write_data_i;
    end
  end

  // Flop-array storage so the asynchronous reset clears every register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .reserve_valid_i (bus.reserve_valid_i),
    .reserve_addr_i  (bus.reserve_addr_i),
    .write_enable_i  (bus.write_enable_i),
    .write_addr_i    (bus.write_addr_i),
    .reserve_ready_o (bus.reserve_ready_o),
    .busy_count_o    (bus.busy_count_o),
    .busy_o          (busy)
  );

  // Read ports: same-cycle writeback to the addressed register is forwarded
  // (data and a cleared busy bit) when bypass is enabled.
  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              fwd;

    assign addr = bus.read_addr_i[gi*ADDR_W +: ADDR_W];
    assign fwd  = BYPASS && wr_hit && (bus.write_addr_i == addr);
    assign bus.read_data_o[gi*DATA_W +: DATA_W] = fwd ? bus.write_data_i : mem_q[addr];
    assign bus.read_busy_o[gi] = fwd ? 1'b0 : busy[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: two instances (bypass on / off) share all stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] rd_addr = '0;
  logic        rv = 1'b0;
  logic [4:0]  ra = '0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(3)) bus_a ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(3)) bus_b ();

  assign bus_a.read_addr_i     = rd_addr;
  assign bus_a.reserve_valid_i = rv;
  assign bus_a.reserve_addr_i  = ra;
  assign bus_a.write_enable_i  = we;
  assign bus_a.write_addr_i    = wa;
  assign bus_a.write_data_i    = wd;
  assign bus_b.read_addr_i     = rd_addr;
  assign bus_b.reserve_valid_i = rv;
  assign bus_b.reserve_addr_i  = ra;
  assign bus_b.write_enable_i  = we;
  assign bus_b.write_addr_i    = wa;
  assign bus_b.write_data_i    = wd;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(3), .BYPASS(1'b1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .READ_PORTS(3), .BYPASS(1'b0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  typedef struct {
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic             rv;
    logic [4:0]       ra;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] ed_a;
    logic [2:0][31:0] ed_b;
    logic [2:0]       eb_a;
    logic [2:0]       eb_b;
    logic             rdy;
    logic [5:0]       cnt;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(
    input logic we_v, input logic [4:0] wa_v, input logic [31:0] wd_v,
    input logic rv_v, input logic [4:0] ra_v,
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
    input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
    input logic [2:0] eba, input logic [2:0] ebb,
    input logic rdy_v, input logic [5:0] cnt_v);
    vec_t v;
    v.we = we_v; v.wa = wa_v; v.wd = wd_v; v.rv = rv_v; v.ra = ra_v;
    v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2;
    v.ed_a[0] = a0; v.ed_a[1] = a1; v.ed_a[2] = a2;
    v.ed_b[0] = b0; v.ed_b[1] = b1; v.ed_b[2] = b2;
    v.eb_a = eba; v.eb_b = ebb; v.rdy = rdy_v; v.cnt = cnt_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge, then settle before sampling.
  task automatic drive(input logic we_v, input logic [4:0] wa_v, input logic [31:0] wd_v,
                       input logic rv_v, input logic [4:0] ra_v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = we_v; wa = wa_v; wd = wd_v; rv = rv_v; ra = ra_v;
    rd_addr = {r2, r1, r0};
    #1;
  endtask

  function automatic logic [31:0] dat_a(input int p);
    return bus_a.read_data_o[p*32 +: 32];
  endfunction

  function automatic logic [31:0] dat_b(input int p);
    return bus_b.read_data_o[p*32 +: 32];
  endfunction

  initial begin
    // Table: r0 behaviour, reserve/retry, writeback clear, same-cycle
    // reserve+write, mixed reserve/clear, bypass vs stored reads.
    vecs[0]  = mk(0, 0, 0, 0, 0,   0, 1, 2,  0, 0, 0,  0, 0, 0,  3'b000, 3'b000, 0, 0);
    vecs[1]  = mk(1, 0, 32'h12345678, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  3'b000, 3'b000, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0,  0, 0, 0,  3'b000, 3'b000, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 3,   3, 0, 0,  0, 0, 0,  0, 0, 0,  3'b000, 3'b000, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 3,   3, 0, 0,  0, 0, 0,  0, 0, 0,  3'b001, 3'b001, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0,   3, 3, 0,  0, 0, 0,  0, 0, 0,  3'b011, 3'b011, 0, 1);
    vecs[6]  = mk(1, 3, 32'h55, 0, 0,  3, 3, 3,  32'h55, 32'h55, 32'h55,  0, 0, 0,  3'b000, 3'b111, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,   3, 3, 3,  32'h55, 32'h55, 32'h55,  32'h55, 32'h55, 32'h55,  3'b000, 3'b000, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 9,   9, 0, 3,  0, 0, 32'h55,  0, 0, 32'h55,  3'b000, 3'b000, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0,   9, 9, 9,  0, 0, 0,  0, 0, 0,  3'b111, 3'b111, 0, 1);
    vecs[10] = mk(1, 9, 32'h99, 1, 9,  9, 9, 9,  32'h99, 32'h99, 32'h99,  0, 0, 0,  3'b000, 3'b111, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0,   9, 9, 9,  32'h99, 32'h99, 32'h99,  32'h99, 32'h99, 32'h99,  3'b111, 3'b111, 0, 1);
    vecs[12] = mk(1, 9, 32'h77, 1, 10,  10, 9, 2,  0, 32'h77, 0,  0, 32'h99, 0,  3'b000, 3'b010, 1, 1);
    vecs[13] = mk(0, 0, 0, 0, 0,   10, 9, 2,  0, 32'h77, 0,  0, 32'h77, 0,  3'b001, 3'b001, 0, 1);
    vecs[14] = mk(1, 4, 32'hA5A5A5A5, 0, 0,  4, 4, 4,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,  0, 0, 0,  3'b000, 3'b000, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0,   4, 4, 4,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,  3'b000, 3'b000, 0, 1);
    vecs[16] = mk(1, 10, 32'h10, 0, 0,  10, 4, 3,  32'h10, 32'hA5A5A5A5, 32'h55,  0, 32'hA5A5A5A5, 32'h55,  3'b000, 3'b001, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0,   10, 4, 3,  32'h10, 32'hA5A5A5A5, 32'h55,  32'h10, 32'hA5A5A5A5, 32'h55,  3'b000, 3'b000, 0, 0);

    // Reset state while reset is held.
    rd_addr = {5'd2, 5'd1, 5'd0};
    repeat (2) @(negedge clk);
    #1;
    chk("reset cnt_a", 32'(bus_a.busy_count_o), 32'd0);
    chk("reset busy_a", 32'(bus_a.read_busy_o), 32'd0);
    chk("reset data_a1", dat_a(1), 32'd0);
    $display("reset: cnt=%0d busy=%b", bus_a.busy_count_o, bus_a.read_busy_o);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra,
            vecs[i].rd[0], vecs[i].rd[1], vecs[i].rd[2]);
      $display("vec %0d: we=%0b wa=%0d wd=%h rv=%0b ra=%0d rd=%0d/%0d/%0d -> rdy=%0b cnt=%0d busy_a=%b busy_b=%b",
               i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra,
               vecs[i].rd[0], vecs[i].rd[1], vecs[i].rd[2],
               bus_a.reserve_ready_o, bus_a.busy_count_o, bus_a.read_busy_o, bus_b.read_busy_o);
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("v%0d data_a%0d", i, p), dat_a(p), vecs[i].ed_a[p]);
        chk($sformatf("v%0d data_b%0d", i, p), dat_b(p), vecs[i].ed_b[p]);
      end
      chk($sformatf("v%0d busy_a", i), 32'(bus_a.read_busy_o), 32'(vecs[i].eb_a));
      chk($sformatf("v%0d busy_b", i), 32'(bus_b.read_busy_o), 32'(vecs[i].eb_b));
      chk($sformatf("v%0d ready_a", i), 32'(bus_a.reserve_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("v%0d ready_b", i), 32'(bus_b.reserve_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("v%0d cnt_a", i), 32'(bus_a.busy_count_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d cnt_b", i), 32'(bus_b.busy_count_o), 32'(vecs[i].cnt));
    end

    // Fill: reserve r1..r31 on consecutive cycles.
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 1, 5'(i), 5'(i), 0, 0);
      $display("fill reserve r%0d: rdy=%0b cnt=%0d", i, bus_a.reserve_ready_o, bus_a.busy_count_o);
      chk($sformatf("fill rdy r%0d", i), 32'(bus_a.reserve_ready_o), 32'd1);
      chk($sformatf("fill cnt r%0d", i), 32'(bus_a.busy_count_o), 32'(i - 1));
    end
    drive(0, 0, 0, 1, 5'd5, 5'd1, 5'd17, 5'd31);
    $display("fill done: cnt=%0d busy=%b retry r5 rdy=%0b", bus_a.busy_count_o, bus_a.read_busy_o, bus_a.reserve_ready_o);
    chk("fill full cnt", 32'(bus_a.busy_count_o), 32'd31);
    chk("fill full busy", 32'(bus_a.read_busy_o), 32'b111);
    chk("fill retry r5 rdy", 32'(bus_a.reserve_ready_o), 32'd0);

    // Drain: write every register back, count falls by one per cycle.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'h100 + 32'(i), 0, 0, 5'(i), 0, 0);
      $display("drain write r%0d: cnt=%0d data_a=%h", i, bus_a.busy_count_o, dat_a(0));
      chk($sformatf("drain cnt r%0d", i), 32'(bus_a.busy_count_o), 32'(32 - i));
      chk($sformatf("drain fwd r%0d", i), dat_a(0), 32'h100 + 32'(i));
    end
    drive(0, 0, 0, 0, 0, 5'd31, 5'd1, 5'd16);
    $display("drain done: cnt=%0d busy=%b", bus_b.busy_count_o, bus_b.read_busy_o);
    chk("drain final cnt", 32'(bus_a.busy_count_o), 32'd0);
    chk("drain final busy", 32'(bus_b.read_busy_o), 32'd0);
    chk("drain r31", dat_b(0), 32'h11F);
    chk("drain r1", dat_b(1), 32'h101);
    chk("drain r16", dat_b(2), 32'h110);

    // Reset mid-run after a write and a pending reservation.
    drive(1, 5'd5, 32'hDEADBEEF, 1, 5'd7, 5'd5, 5'd7, 5'd0);
    drive(0, 0, 0, 0, 0, 5'd5, 5'd7, 5'd0);
    $display("pre-reset: r5=%h busy=%b cnt=%0d", dat_b(0), bus_b.read_busy_o, bus_b.busy_count_o);
    chk("pre-reset r5", dat_b(0), 32'hDEADBEEF);
    chk("pre-reset busy", 32'(bus_b.read_busy_o), 32'b010);
    chk("pre-reset cnt", 32'(bus_b.busy_count_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("in reset: r5=%h busy=%b cnt=%0d", dat_a(0), bus_a.read_busy_o, bus_a.busy_count_o);
    chk("async reset r5 a", dat_a(0), 32'd0);
    chk("async reset r5 b", dat_b(0), 32'd0);
    chk("async reset busy a", 32'(bus_a.read_busy_o), 32'd0);
    chk("async reset busy b", 32'(bus_b.read_busy_o), 32'd0);
    chk("async reset cnt", 32'(bus_a.busy_count_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 5'd7, 5'd5, 5'd7, 5'd31);
    $display("post-reset: r5=%h r31=%h rdy r7=%0b cnt=%0d", dat_b(0), dat_b(2), bus_a.reserve_ready_o, bus_a.busy_count_o);
    chk("post-reset r5", dat_b(0), 32'd0);
    chk("post-reset r31", dat_b(2), 32'd0);
    chk("post-reset r7 rdy", 32'(bus_a.reserve_ready_o), 32'd1);
    chk("post-reset cnt", 32'(bus_a.busy_count_o), 32'd0);
    drive(0, 0, 0, 0, 0, 5'd5, 5'd7, 5'd31);
    chk("post-reset r7 busy", 32'(bus_a.read_busy_o), 32'b010);
    chk("post-reset cnt 1", 32'(bus_a.busy_count_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
